// File: rtl/spi_bus_scheduler.sv
// rtl/spi_bus_scheduler.sv - two-requester SPI mode-3 master with round-robin arbitration per transaction
// A granted requester keeps CS low across its bytes until it sends one marked last.
module spi_bus_scheduler #(
  parameter int CLK_DIV = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_last_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  input  logic       req1_last_i,
  output logic       req1_ready_o,
  output logic       rsp0_valid_o,
  output logic       rsp1_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       busy_o,
  output logic       spi_clk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_o,
  input  logic       spi_miso_i
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_NEXT, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       last_q;
  logic       owner;
  logic       last_grant;

  logic       grant_sel;
  logic       sel;
  logic       hs_fire;
  logic [7:0] hs_data;
  logic       hs_last;

  // With both requesters valid the one not granted last wins; a lone requester always wins.
  assign grant_sel = (req0_valid_i && req1_valid_i) ? ~last_grant : req1_valid_i;
  assign sel       = (state == IDLE) ? grant_sel : owner;
  assign hs_data   = sel ? req1_data_i : req0_data_i;
  assign hs_last   = sel ? req1_last_i : req0_last_i;
  assign hs_fire   = sel ? (req1_valid_i && req1_ready_o) : (req0_valid_i && req0_ready_o);
  assign busy_o    = (state != IDLE);

  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    if (sys_rst_n) begin
      if (state == IDLE) begin
        req0_ready_o = req0_valid_i && !grant_sel;
        req1_ready_o = req1_valid_i && grant_sel;
      end else if (state == WAIT_NEXT) begin
        req0_ready_o = !owner;
        req1_ready_o = owner;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      div_cnt      <= 8'd0;
      bit_cnt      <= 3'd0;
      tx_sh        <= 8'd0;
      rx_sh        <= 8'd0;
      last_q       <= 1'b0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      spi_cs_o     <= 1'b1;
      spi_clk_o    <= 1'b1;
      spi_mosi_o   <= 1'b0;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp_data_o   <= 8'd0;
    end else begin
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (hs_fire) begin
            state      <= SETUP;
            owner      <= sel;
            last_grant <= sel;
            tx_sh      <= hs_data;
            last_q     <= hs_last;
            div_cnt    <= DIV_LOAD;
            spi_cs_o   <= 1'b0;
            spi_mosi_o <= hs_data[7];
          end
        end
        SETUP: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            state     <= SHIFT;
            spi_clk_o <= 1'b0;
            div_cnt   <= DIV_LOAD;
            bit_cnt   <= 3'd0;
          end
        end
        SHIFT: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (!spi_clk_o) begin
            spi_clk_o <= 1'b1;
            rx_sh     <= {rx_sh[6:0], spi_miso_i};
            div_cnt   <= DIV_LOAD;
          end else if (bit_cnt == 3'd7) begin
            rsp0_valid_o <= !owner;
            rsp1_valid_o <= owner;
            rsp_data_o   <= rx_sh;
            if (last_q) begin
              state      <= GAP;
              spi_cs_o   <= 1'b1;
              spi_mosi_o <= 1'b0;
              div_cnt    <= DIV_LOAD;
            end else begin
              state <= WAIT_NEXT;
            end
          end else begin
            // Falling SCLK: the only point where MOSI advances to the next bit.
            spi_clk_o  <= 1'b0;
            bit_cnt    <= bit_cnt + 3'd1;
            spi_mosi_o <= tx_sh[6];
            tx_sh      <= {tx_sh[6:0], 1'b0};
            div_cnt    <= DIV_LOAD;
          end
        end
        WAIT_NEXT: begin
          if (hs_fire) begin
            state      <= SHIFT;
            tx_sh      <= hs_data;
            last_q     <= hs_last;
            spi_clk_o  <= 1'b0;
            spi_mosi_o <= hs_data[7];
            div_cnt    <= DIV_LOAD;
            bit_cnt    <= 3'd0;
          end
        end
        GAP: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_bus_scheduler.sv
// tb/tb_spi_bus_scheduler.sv - scoreboard bench for spi_bus_scheduler
// Stimulus pushes expected responses; a monitor pops them as rsp pulses appear.
module tb_spi_bus_scheduler;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, rsp_data;
  logic       rsp0, rsp1, busy, spi_clk, spi_mosi, spi_cs, spi_miso;
  logic       b_req0_valid, b_req0_last, b_req0_ready, b_req1_ready;
  logic [7:0] b_req0_data, b_rsp_data;
  logic       b_rsp0, b_rsp1, b_busy, b_clk, b_mosi, b_cs;

  typedef struct {
    int         d;
    int         r;
    logic [7:0] data;
    int         cyc;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] slv_q[$];
  logic [7:0] cur;
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         cs_cnt = 0, rises = 0, s_cnt = 0, fr_len = 0, fr_rises = 0;
  logic [31:0] mosi_sh = 0, fr_mosi = 0;
  logic       prev_cs = 1'b1, prev_clk = 1'b1;
  logic       watch_r0 = 1'b0;
  int         r0_hits = 0;
  int         h, h1, h2, h3, t, viol, tog;
  logic       prev;

  spi_bus_scheduler #(.CLK_DIV(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_last_i(req0_last), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_last_i(req1_last), .req1_ready_o(req1_ready),
    .rsp0_valid_o(rsp0), .rsp1_valid_o(rsp1), .rsp_data_o(rsp_data), .busy_o(busy),
    .spi_clk_o(spi_clk), .spi_mosi_o(spi_mosi), .spi_cs_o(spi_cs), .spi_miso_i(spi_miso)
  );

  spi_bus_scheduler #(.CLK_DIV(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req0_valid_i(b_req0_valid), .req0_data_i(b_req0_data), .req0_last_i(b_req0_last), .req0_ready_o(b_req0_ready),
    .req1_valid_i(1'b0), .req1_data_i(8'h00), .req1_last_i(1'b0), .req1_ready_o(b_req1_ready),
    .rsp0_valid_o(b_rsp0), .rsp1_valid_o(b_rsp1), .rsp_data_o(b_rsp_data), .busy_o(b_busy),
    .spi_clk_o(b_clk), .spi_mosi_o(b_mosi), .spi_cs_o(b_cs), .spi_miso_i(1'b0)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int d, input int r);
    if (d == 1) return b_req0_ready;
    return (r == 1) ? req1_ready : req0_ready;
  endfunction

  // Waits for the ready of (dut d, requester r); the handshake edge number is returned in hs_cyc.
  task automatic hs(input int d, input int r, input logic [7:0] slv, input int lat, output int hs_cyc);
    int n = 0;
    sb_t e;
    #1;
    while (!rdy(d, r) && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    n_tests++;
    hs_cyc = cyc + 1;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL hs_timeout: dut%0d req%0d waited %0d cycles, limit 200", d, r, n);
    end else begin
      if (d == 0) slv_q.push_back(slv);
      if (lat >= 0) begin
        e.d = d; e.r = r; e.data = slv; e.cyc = hs_cyc + lat;
        sb_q.push_back(e);
      end
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_idle(output int t_idle);
    int n = 0;
    @(negedge sys_clk);
    while (busy && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    n_tests++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL idle_timeout: busy after %0d cycles, limit 300", n);
    end
    t_idle = cyc;
  endtask

  task automatic sb_pop(input int d, input logic r, input logic [7:0] data, input logic both);
    sb_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: dut%0d rsp%0d data 0x%0h at cycle %0d, none expected", d, r, data, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.d != d || e.r != int'(r) || e.data !== data || e.cyc != cyc || both) begin
        n_fail++;
        $display("FAIL sb_rsp: got dut%0d rsp%0d data 0x%0h cycle %0d both %0b, expected dut%0d rsp%0d data 0x%0h cycle %0d",
                 d, r, data, cyc, both, e.d, e.r, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (rsp0 || rsp1) sb_pop(0, rsp1, rsp_data, rsp0 && rsp1);
    if (b_rsp0 || b_rsp1) sb_pop(1, b_rsp1, b_rsp_data, b_rsp0 && b_rsp1);
    if (watch_r0 && busy && req0_ready) r0_hits++;
  end

  // Bus frame recorder and SPI slave model for the CLK_DIV=2 instance.
  always @(negedge sys_clk) begin
    if (!spi_cs) begin
      cs_cnt++;
      if (spi_clk && !prev_clk) begin
        rises++;
        mosi_sh = {mosi_sh[30:0], spi_mosi};
        s_cnt++;
        if (s_cnt == 8) begin
          s_cnt = 0;
          if (slv_q.size() != 0) void'(slv_q.pop_front());
        end
      end
    end else begin
      if (!prev_cs) begin
        fr_len = cs_cnt; fr_rises = rises; fr_mosi = mosi_sh;
      end
      cs_cnt = 0; rises = 0; mosi_sh = 0; s_cnt = 0;
    end
    prev_cs = spi_cs;
    prev_clk = spi_clk;
    if (slv_q.size() != 0) begin
      cur = slv_q[0];
      spi_miso = cur[3'(7 - s_cnt)];
    end else begin
      spi_miso = 1'b0;
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    spi_miso = 1'b0;
    b_req0_valid = 1'b0; b_req0_data = 8'h00; b_req0_last = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h5A; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'hC3; req1_last = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_cs", spi_cs, 1);
    chk("rst_sclk", spi_clk, 1);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_valid", {rsp0, rsp1}, 0);

    // Both valid out of reset: grants go 0,1,0 and the first lands on the first edge.
    sys_rst_n = 1'b1;
    t = cyc;
    hs(0, 0, 8'h10, 34, h1);
    chk("first_hs_edge", h1, t + 1);
    hs(0, 1, 8'h20, 34, h2);
    chk("rr_grant1_spacing", h2 - h1, 37);
    hs(0, 0, 8'h30, 34, h3);
    chk("rr_grant2_spacing", h3 - h2, 37);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(t);

    // Single byte 0xA5, slave returns 0x3C.
    req0_valid = 1'b1; req0_data = 8'hA5; req0_last = 1'b1;
    hs(0, 0, 8'h3C, 34, h);
    req0_valid = 1'b0;
    wait_idle(t);
    chk("gap_to_idle", t - h, 36);
    chk("cs_low_len", fr_len, 34);
    chk("sclk_rises", fr_rises, 8);
    chk("mosi_bits", fr_mosi[7:0], 8'hA5);

    // req1 two-byte transaction while req0 keeps asking.
    req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h11; req1_last = 1'b0;
    r0_hits = 0;
    watch_r0 = 1'b1;
    hs(0, 1, 8'hA1, 34, h1);
    req1_data = 8'h22; req1_last = 1'b1;
    hs(0, 1, 8'hB2, 32, h2);
    req1_valid = 1'b0;
    chk("wait_next_hs", h2 - h1, 35);
    hs(0, 0, 8'hC3, 34, h3);
    watch_r0 = 1'b0;
    chk("r0_after_gap", h3 - h2, 35);
    chk("r0_ready_blocked", r0_hits, 0);
    chk("multi_cs_len", fr_len, 67);
    chk("multi_rises", fr_rises, 16);
    chk("multi_mosi", fr_mosi[15:0], 16'h1122);
    req0_valid = 1'b0;
    wait_idle(t);

    // Owner stalls in WAIT_NEXT for 50 cycles.
    req0_valid = 1'b1; req0_data = 8'h81; req0_last = 1'b0;
    hs(0, 0, 8'h18, 34, h1);
    req0_valid = 1'b0;
    repeat (36) @(negedge sys_clk);
    viol = 0;
    repeat (50) begin
      if (spi_cs !== 1'b0 || spi_clk !== 1'b1 || busy !== 1'b1 || req0_ready !== 1'b1) viol++;
      @(negedge sys_clk);
    end
    chk("wait_next_hold", viol, 0);
    req0_valid = 1'b1; req0_data = 8'h7E; req0_last = 1'b1;
    hs(0, 0, 8'hE7, 32, h2);
    req0_valid = 1'b0;
    wait_idle(t);
    chk("resume_rises", fr_rises, 16);
    chk("resume_mosi", fr_mosi[15:0], 16'h817E);

    // Reset during the 4th SCLK low phase.
    req0_valid = 1'b1; req0_data = 8'hF0; req0_last = 1'b1;
    hs(0, 0, 8'h99, -1, h);
    req0_valid = 1'b0;
    repeat (15) @(negedge sys_clk);
    chk("abort_low_phase", spi_clk, 0);
    sys_rst_n = 1'b0;
    slv_q.delete();
    #1;
    chk("abort_cs", spi_cs, 1);
    chk("abort_sclk", spi_clk, 1);
    chk("abort_mosi", spi_mosi, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    req0_valid = 1'b1; req0_data = 8'h3C; req0_last = 1'b1;
    hs(0, 0, 8'h42, 34, h);
    req0_valid = 1'b0;
    wait_idle(t);
    chk("post_abort_cs_len", fr_len, 34);

    // CLK_DIV=1 instance: 0xFF out, MISO tied low.
    b_req0_valid = 1'b1; b_req0_data = 8'hFF; b_req0_last = 1'b1;
    hs(1, 0, 8'h00, 17, h);
    b_req0_valid = 1'b0;
    prev = b_clk;
    tog = 0;
    repeat (17) begin
      @(negedge sys_clk);
      if (b_clk !== prev) tog++;
      prev = b_clk;
    end
    chk("div1_toggles", tog, 16);
    repeat (10) @(negedge sys_clk);

    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded 300000 time units");
    $fatal(1);
  end
endmodule

// File: doc/spi_bus_scheduler.md
SPI_BUS_SCHEDULER -- requirements
Module: spi_bus_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in sys_clk cycles; legal range 1..255.
REQ-002 SHALL have port sys_clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid_i / req1_valid_i, input, 1 each: requester presents a byte.
REQ-005 SHALL have ports req0_data_i / req1_data_i, input, 8 each: byte to transmit, MSB first.
REQ-006 SHALL have ports req0_last_i / req1_last_i, input, 1 each: byte ends the transaction; CS is released after it.
REQ-007 SHALL have ports req0_ready_o / req1_ready_o, output, 1 each: byte accepted when valid and ready are both high at a sys_clk edge.
REQ-008 SHALL have ports rsp0_valid_o / rsp1_valid_o, output, 1 each: one-cycle pulse carrying the received byte.
REQ-009 SHALL have port rsp_data_o, output, 8: MISO byte; valid only while an rsp valid is high.
REQ-010 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-011 SHALL have ports spi_clk_o, spi_mosi_o and spi_cs_o, output, 1 each: SPI bus, mode 3 (SCLK idles high), CS active-low.
REQ-012 SHALL have port spi_miso_i, input, 1: SPI data from the slave; already synchronous to sys_clk.

Function
REQ-013 States SHALL be IDLE, SETUP, SHIFT, WAIT_NEXT and GAP.
REQ-014 In IDLE, ready SHALL be asserted to exactly one requester: the arbitration winner among valid requesters; all ready outputs low if none is valid.
REQ-015 Arbitration SHALL be round-robin at transaction granularity: when both are valid, the winner is the requester not granted last; after reset requester 0 has priority.
REQ-016 A granted requester SHALL own the bus until its byte with last=1 completes; the other requester's ready stays low throughout.
REQ-017 On the IDLE handshake edge, the scheduler SHALL latch data and last and enter SETUP.
REQ-018 SETUP SHALL last CLK_DIV cycles with spi_cs_o=0, spi_clk_o=1 and spi_mosi_o=data[7].
REQ-019 SHIFT SHALL run 8 bit periods, each CLK_DIV cycles with spi_clk_o=0 followed by CLK_DIV cycles with spi_clk_o=1.
REQ-020 spi_mosi_o SHALL change only at falling SCLK transitions, presenting bits 6..0 at the 2nd..8th falling edges.
REQ-021 spi_miso_i SHALL be sampled on the sys_clk edge where spi_clk_o goes 0->1 and shifted in MSB first.
REQ-022 At the end of the 8th high phase, the scheduler SHALL pulse the owner's rsp valid for 1 cycle with rsp_data_o = the received byte.
REQ-023 Byte latency SHALL be (CLK_DIV + 16*CLK_DIV) cycles from the handshake to the rsp pulse.
REQ-024 After a byte with last=0, the scheduler SHALL enter WAIT_NEXT: CS held low, SCLK high, MOSI holds its last bit, ready asserted to the owner only.
REQ-025 On the WAIT_NEXT handshake, the scheduler SHALL enter SHIFT directly, with no SETUP, and drive MOSI=data[7] on the next cycle.
REQ-026 WAIT_NEXT SHALL hold indefinitely while the owner is not valid; there is no timeout.
REQ-027 After a byte with last=1, the scheduler SHALL enter GAP: CS high, MOSI 0, SCLK high, for CLK_DIV cycles, then IDLE. No ready is asserted in GAP.
REQ-028 The rsp pulse SHALL coincide with the first cycle of WAIT_NEXT or GAP.
REQ-029 Ready SHALL be low in SETUP, SHIFT and GAP; inputs are ignored there.
REQ-030 The divider counter SHALL be 8 bits and the bit counter 3 bits; neither wraps mid-byte.

Reset
REQ-031 On sys_rst_n low, the scheduler SHALL immediately force spi_cs_o=1, spi_clk_o=1, spi_mosi_o=0, all ready and rsp valids 0, busy_o=0, rsp_data_o=0, state IDLE, and round-robin pointer favouring requester 0.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction, drop any pending response, and cause no SCLK edge on deassertion.
REQ-033 The first handshake SHALL be possible on the first sys_clk edge after sys_rst_n rises.

Verification
REQ-034 CLK_DIV=2, req0 sends 0xA5 with last=1, slave returns 0x3C -> CS low for 34 cycles, 8 SCLK pulses, MOSI 1,0,1,0,0,1,0,1, rsp0 pulse with rsp_data_o=0x3C at cycle 34 after the handshake, CS high 2 cycles, then IDLE.
REQ-035 req0 and req1 valid on the same cycle after reset -> req0 is served first; then req1 is served after req0's GAP; with both still valid, grants alternate 0,1,0.
REQ-036 req1 sends 0x11 (last=0) then 0x22 (last=1), with req0 valid throughout -> CS stays low across both bytes, no SETUP before byte 2, req0_ready_o stays 0 until GAP ends.
REQ-037 WAIT_NEXT held for 50 cycles with the owner invalid -> CS stays 0 and SCLK stays 1 with no edges; the transfer resumes normally when the owner becomes valid.
REQ-038 sys_rst_n pulsed low at the 4th SCLK low phase -> outputs return to CS=1, SCLK=1, MOSI=0 asynchronously; no rsp pulse occurs; the next request starts from SETUP.
REQ-039 CLK_DIV=1, byte 0xFF with MISO tied 0 -> SCLK toggles every cycle, rsp_data_o=0x00, latency 17 cycles.
